// File: rtl/exe_stage_pkg.sv
// Shared CPU package: datapath width, ALU function codes and the opcode
// constants used by decode and execute.
package exe_stage_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_LD  = 3'b110,  // load address: add
    ALU_ST  = 3'b111   // store address: add
  } alu_func_e;

  localparam logic [5:0] OP_BEQ = 6'b000110;
  // Decode-side opcodes; execute only looks at OP_BEQ.
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_LW  = 6'b100000;
  localparam logic [5:0] OP_BNE = 6'b000100;

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational ALU.
//   a, b   : operands (W bits)
//   func   : ALU function code
//   result : W-bit result, arithmetic modulo 2^W, overflow ignored
//   zero   : result == 0
module alu
  import exe_stage_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  alu_func_e    func,
  output logic [W-1:0] result,
  output logic         zero
);

  always_comb begin
    result = '0;
    case (func)
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = a + b;  // ADD, LD, ST
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/exe_stage.sv
// Execute stage with EXE/MEM output register.
//   Upstream : in_valid / in_ready, ir/pc/extend/reg1/reg2_exe,
//              alu_func_exe, alu_in2_select
//   Control  : flush kills the held entry and anything accepted this cycle
//   Downstream: out_valid / out_ready, *_mem registered fields
// All *_mem outputs come straight from flops; the only combinational
// input-to-output path is out_ready -> in_ready.
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int         DATA_W = exe_stage_pkg::DATA_W,
  parameter logic [5:0] OP_BEQ = exe_stage_pkg::OP_BEQ
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] ir_exe,
  input  logic [DATA_W-1:0] pc_exe,
  input  logic [DATA_W-1:0] extend_exe,
  input  logic [DATA_W-1:0] reg1_exe,
  input  logic [DATA_W-1:0] reg2_exe,
  input  logic [2:0]        alu_func_exe,
  input  logic              alu_in2_select,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ir_mem,
  output logic [DATA_W-1:0] pc_mem,
  output logic [DATA_W-1:0] alu_result_mem,
  output logic [DATA_W-1:0] store_data_mem,
  output logic              zero_mem,
  output logic              branch_taken_mem,
  output logic [DATA_W-1:0] branch_target_mem
);

  // Operand mux and ALU
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_zero;

  assign alu_b = alu_in2_select ? extend_exe : reg2_exe;

  alu #(.W(DATA_W)) u_alu (
    .a      (reg1_exe),
    .b      (alu_b),
    .func   (alu_func_e'(alu_func_exe)),
    .result (alu_res),
    .zero   (alu_zero)
  );

  // Branch unit: compare always uses the register operands.
  logic              br_taken;
  logic [DATA_W-1:0] br_target;

  assign br_taken  = (ir_exe[31:26] == OP_BEQ) && (reg1_exe == reg2_exe);
  assign br_target = pc_exe + DATA_W'(4) + (extend_exe << 2);

  // EXE/MEM register
  logic              out_valid_q,     out_valid_d;
  logic [DATA_W-1:0] ir_q,            ir_d;
  logic [DATA_W-1:0] pc_q,            pc_d;
  logic [DATA_W-1:0] alu_result_q,    alu_result_d;
  logic [DATA_W-1:0] store_data_q,    store_data_d;
  logic              zero_q,          zero_d;
  logic              branch_taken_q,  branch_taken_d;
  logic [DATA_W-1:0] branch_target_q, branch_target_d;

  logic accept;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d     = out_valid_q;
    ir_d            = ir_q;
    pc_d            = pc_q;
    alu_result_d    = alu_result_q;
    store_data_d    = store_data_q;
    zero_d          = zero_q;
    branch_taken_d  = branch_taken_q;
    branch_target_d = branch_target_q;

    if (accept) begin
      out_valid_d     = 1'b1;
      ir_d            = ir_exe;
      pc_d            = pc_exe;
      alu_result_d    = alu_res;
      store_data_d    = reg2_exe;
      zero_d          = alu_zero;
      branch_taken_d  = br_taken;
      branch_target_d = br_target;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;  // consumed, data fields hold
    end

    // Flush wins over stall and accept; a flushed branch must never redirect.
    if (flush) begin
      out_valid_d    = 1'b0;
      branch_taken_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q     <= 1'b0;
      ir_q            <= '0;
      pc_q            <= '0;
      alu_result_q    <= '0;
      store_data_q    <= '0;
      zero_q          <= 1'b0;
      branch_taken_q  <= 1'b0;
      branch_target_q <= '0;
    end else begin
      out_valid_q     <= out_valid_d;
      ir_q            <= ir_d;
      pc_q            <= pc_d;
      alu_result_q    <= alu_result_d;
      store_data_q    <= store_data_d;
      zero_q          <= zero_d;
      branch_taken_q  <= branch_taken_d;
      branch_target_q <= branch_target_d;
    end
  end

  assign out_valid         = out_valid_q;
  assign ir_mem            = ir_q;
  assign pc_mem            = pc_q;
  assign alu_result_mem    = alu_result_q;
  assign store_data_mem    = store_data_q;
  assign zero_mem          = zero_q;
  assign branch_taken_mem  = branch_taken_q;
  assign branch_target_mem = branch_target_q;

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage: directed literal checks plus randomized traffic
// compared against a behavioural model every cycle.
module tb_exe_stage;
  import exe_stage_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0, alu_in2_select = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [W-1:0] ir_exe = '0, pc_exe = '0, extend_exe = '0, reg1_exe = '0, reg2_exe = '0;
  logic [2:0]   alu_func_exe = '0;
  logic         in_ready, out_valid, zero_mem, branch_taken_mem;
  logic [W-1:0] ir_mem, pc_mem, alu_result_mem, store_data_mem, branch_target_mem;

  exe_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ir_exe(ir_exe), .pc_exe(pc_exe), .extend_exe(extend_exe),
    .reg1_exe(reg1_exe), .reg2_exe(reg2_exe), .alu_func_exe(alu_func_exe),
    .alu_in2_select(alu_in2_select), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .ir_mem(ir_mem), .pc_mem(pc_mem),
    .alu_result_mem(alu_result_mem), .store_data_mem(store_data_mem),
    .zero_mem(zero_mem), .branch_taken_mem(branch_taken_mem),
    .branch_target_mem(branch_target_mem)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [W-1:0] ref_alu(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    case (f)
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: return a + b;
    endcase
  endfunction

  logic         m_valid = 1'b0, m_zero = 1'b0, m_bt = 1'b0;
  logic [W-1:0] m_ir = '0, m_pc = '0, m_res = '0, m_st = '0, m_tgt = '0;
  logic         m_rdy, m_acc;
  logic [W-1:0] m_newres;

  assign m_rdy    = !m_valid || out_ready;
  assign m_acc    = in_valid && m_rdy;
  assign m_newres = ref_alu(alu_func_exe, reg1_exe, alu_in2_select ? extend_exe : reg2_exe);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0; m_ir <= '0; m_pc <= '0; m_res <= '0;
      m_st <= '0; m_zero <= 1'b0; m_bt <= 1'b0; m_tgt <= '0;
    end else begin
      if (m_acc) begin
        m_valid <= 1'b1;
        m_ir    <= ir_exe;
        m_pc    <= pc_exe;
        m_res   <= m_newres;
        m_st    <= reg2_exe;
        m_zero  <= (m_newres == 0);
        m_bt    <= (ir_exe[31:26] == 6'b000110) && (reg1_exe == reg2_exe);
        m_tgt   <= pc_exe + 4 + extend_exe * 4;
      end else if (m_valid && out_ready) begin
        m_valid <= 1'b0;
      end
      if (flush) begin
        m_valid <= 1'b0;
        m_bt    <= 1'b0;
      end
    end
  end

  // Compare process: inputs change only at negedge+1, so negedge is stable.
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", W'(out_valid), W'(m_valid));
      chk("in_ready", W'(in_ready), W'(m_rdy));
      chk("branch_taken", W'(branch_taken_mem), W'(m_bt));
      if (m_valid) begin
        chk("ir_mem", ir_mem, m_ir);
        chk("pc_mem", pc_mem, m_pc);
        chk("alu_result", alu_result_mem, m_res);
        chk("store_data", store_data_mem, m_st);
        chk("zero_mem", W'(zero_mem), W'(m_zero));
        chk("branch_target", branch_target_mem, m_tgt);
      end
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] ir, input logic [W-1:0] pc,
                       input logic [W-1:0] ext, input logic [W-1:0] r1, input logic [W-1:0] r2,
                       input logic [2:0] f, input logic sel, input logic ordy, input logic fl);
    in_valid = v; ir_exe = ir; pc_exe = pc; extend_exe = ext; reg1_exe = r1; reg2_exe = r2;
    alu_func_exe = f; alu_in2_select = sel; out_ready = ordy; flush = fl;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, W'(out_valid), '0);
    chk({tag, "_in_ready"}, W'(in_ready), W'(1));
    chk({tag, "_bt"}, W'(branch_taken_mem), '0);
    chk({tag, "_zero"}, W'(zero_mem), '0);
    chk({tag, "_ir"}, ir_mem, '0);
    chk({tag, "_pc"}, pc_mem, '0);
    chk({tag, "_res"}, alu_result_mem, '0);
    chk({tag, "_st"}, store_data_mem, '0);
    chk({tag, "_tgt"}, branch_target_mem, '0);
  endtask

  localparam logic [W-1:0] BEQ_IR = {6'b000110, 26'h0};

  initial begin
    #1;
    check_reset_state("reset");
    @(negedge clk); #1;
    rst = 1'b0;

    // add 7 + 5
    drive(1, 32'h0, 32'h10, 32'h0, 32'd7, 32'd5, 3'b000, 0, 1, 0);
    @(negedge clk);
    chk("add_res", alu_result_mem, 32'd12);
    chk("add_zero", W'(zero_mem), '0);
    chk("add_valid", W'(out_valid), W'(1));
    #1;
    // immediate subtract 3 - 3
    drive(1, 32'h0, 32'h14, 32'd3, 32'd3, 32'd99, 3'b001, 1, 1, 0);
    @(negedge clk);
    chk("subi_res", alu_result_mem, 32'd0);
    chk("subi_zero", W'(zero_mem), W'(1));
    chk("subi_store", store_data_mem, 32'd99);
    #1;
    // signed slt: -1 < 1
    drive(1, 32'h0, 32'h18, 32'h0, 32'hFFFF_FFFF, 32'd1, 3'b101, 0, 1, 0);
    @(negedge clk);
    chk("slt_res", alu_result_mem, 32'd1);
    #1;
    // BEQ taken, backward target
    drive(1, BEQ_IR, 32'h100, 32'hFFFF_FFFE, 32'd9, 32'd9, 3'b000, 0, 1, 0);
    @(negedge clk);
    chk("beq_bt", W'(branch_taken_mem), W'(1));
    chk("beq_tgt", branch_target_mem, 32'hFC);
    chk("beq_res", alu_result_mem, 32'h12);
    #1;
    // back-pressure for three cycles
    drive(1, 32'h0, 32'h104, 32'h0, 32'd1, 32'd2, 3'b000, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", W'(in_ready), '0);
      chk("bp_valid", W'(out_valid), W'(1));
      chk("bp_res", alu_result_mem, 32'h12);
      chk("bp_pc", pc_mem, 32'h100);
    end
    #1;
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", W'(in_ready), W'(1));
    @(negedge clk);
    chk("bp_next_res", alu_result_mem, 32'd3);
    chk("bp_next_pc", pc_mem, 32'h104);
    chk("bp_next_bt", W'(branch_taken_mem), '0);
    #1;
    // flush a stalled BEQ
    drive(1, BEQ_IR, 32'h200, 32'd1, 32'd5, 32'd5, 3'b000, 0, 1, 0);
    @(negedge clk);
    chk("fl_bt", W'(branch_taken_mem), W'(1));
    chk("fl_tgt", branch_target_mem, 32'h208);
    #1;
    drive(0, 32'h0, 32'h0, 32'h0, 32'd0, 32'd0, 3'b000, 0, 0, 0);
    @(negedge clk);
    chk("fl_stall_valid", W'(out_valid), W'(1));
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("fl_valid", W'(out_valid), '0);
    chk("fl_bt_cleared", W'(branch_taken_mem), '0);
    #1;
    flush = 1'b0;

    // randomized traffic with one asynchronous mid-stream reset
    for (int n = 0; n < 3000; n++) begin
      logic [W-1:0] r1, r2, ir;
      r1 = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 4)) : W'($urandom);
      r2 = ($urandom_range(0, 3) == 0) ? r1 : W'($urandom);
      ir = W'($urandom);
      if ($urandom_range(0, 1) == 1) ir[31:26] = 6'b000110;
      drive(($urandom_range(0, 3) != 0), ir, W'($urandom), W'($urandom), r1, r2,
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
      if (n == 1500) begin
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("midrst");
        @(negedge clk); #1;
        check_reset_state("midrst_hold");
        rst = 1'b0;
      end
      @(negedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
